// File: rtl/prf_wr_arbiter_pkg.sv
// corep: shared PRF sizing, PR field types and helpers for the PRF write arbiter.
`default_nettype none

package corep;

  localparam int PRF_WR_COUNT             = 8;
  localparam int PRF_BANK_COUNT           = 4;
  localparam int PRF_WR_INPUT_BUFFER_SIZE = 2;
  localparam int XLEN                     = 32;

  typedef logic [6:0]      PR_t;
  typedef logic [4:0]      upper_PR_t;
  typedef logic [1:0]      PR_bank_t;
  typedef logic [XLEN-1:0] XLEN_t;

  // Low PR bits select the bank, the remaining bits select the row inside it.
  function automatic upper_PR_t upper_PR_bits(input PR_t pr);
    return pr[6:2];
  endfunction

  function automatic PR_bank_t PR_bank_bits(input PR_t pr);
    return pr[1:0];
  endfunction

  // Returns {found, index} of the first set request at or after ptr, modulo 8.
  function automatic logic [3:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr);
    logic [3:0] res;
    logic [2:0] idx;
    res = '0;
    for (int i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (!res[3] && req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/prf_wr_arbiter_port_buffer.sv
// prf_wr_port_buffer: small FIFO of {PR, data} for one writeback requester.
`default_nettype none

module prf_wr_port_buffer
  import corep::*;
#(
  parameter int DEPTH = PRF_WR_INPUT_BUFFER_SIZE,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            i_push,
  input  logic [6:0]      i_push_pr,
  input  logic [XLEN-1:0] i_push_data,
  input  logic            i_pop,
  output logic [6:0]      o_head_pr,
  output logic [XLEN-1:0] o_head_data,
  output logic [CW-1:0]   o_count,
  output logic            o_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [6:0]      r_pr   [DEPTH];
  logic [XLEN-1:0] r_data [DEPTH];
  logic            w_push;
  logic            w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_ready     = (r_count < CW'(DEPTH));
  assign o_count     = r_count;
  assign o_head_pr   = r_pr[r_rd_ptr];
  assign o_head_data = r_data[r_rd_ptr];
  assign w_push      = i_push && o_ready;
  assign w_pop       = i_pop && (r_count != '0);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the count gates every read.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_pr[r_wr_ptr]   <= i_push_pr;
      r_data[r_wr_ptr] <= i_push_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/prf_wr_arbiter.sv
// prf_wr_arbiter: round-robin sharing of 4 PRF write banks among 8 buffered requesters.
// Optional macro PRF_WR_ARB_WRBUF_PRIO_EN gives port 0 (WR_BUF) fixed top priority.
`default_nettype none

module prf_wr_arbiter
  import corep::*;
#(
  parameter int PRF_WR_COUNT             = corep::PRF_WR_COUNT,
  parameter int PRF_BANK_COUNT           = corep::PRF_BANK_COUNT,
  parameter int PRF_WR_INPUT_BUFFER_SIZE = corep::PRF_WR_INPUT_BUFFER_SIZE
) (
  input  logic                                 CLK,
  input  logic                                 nRST,
  input  logic [PRF_WR_COUNT-1:0]              wr_req_valid_by_port,
  input  logic [PRF_WR_COUNT-1:0][6:0]         wr_req_PR_by_port,
  input  logic [PRF_WR_COUNT-1:0][XLEN-1:0]    wr_req_data_by_port,
  output logic [PRF_WR_COUNT-1:0]              wr_req_ready_by_port,
  output logic [PRF_BANK_COUNT-1:0]            prf_wr_valid_by_bank,
  output logic [PRF_BANK_COUNT-1:0][4:0]       prf_wr_upper_PR_by_bank,
  output logic [PRF_BANK_COUNT-1:0][XLEN-1:0]  prf_wr_data_by_bank,
  output logic [PRF_BANK_COUNT-1:0]            wb_bcast_valid_by_bank,
  output logic [PRF_BANK_COUNT-1:0][6:0]       wb_bcast_PR_by_bank
);

  localparam int CW = $clog2(PRF_WR_INPUT_BUFFER_SIZE + 1);

  logic [6:0]                                  w_head_pr   [PRF_WR_COUNT];
  logic [XLEN-1:0]                             w_head_data [PRF_WR_COUNT];
  logic [CW-1:0]                               w_count     [PRF_WR_COUNT];
  logic [PRF_WR_COUNT-1:0]                     w_ready;
  logic [PRF_WR_COUNT-1:0]                     w_push;
  logic [PRF_WR_COUNT-1:0]                     w_pop;
  logic [PRF_BANK_COUNT-1:0][PRF_WR_COUNT-1:0] w_grant;

  assign wr_req_ready_by_port = w_ready;
  assign w_push               = wr_req_valid_by_port & w_ready;

  for (genvar p = 0; p < PRF_WR_COUNT; p++) begin : g_port
    prf_wr_port_buffer #(
      .DEPTH (PRF_WR_INPUT_BUFFER_SIZE),
      .CW    (CW)
    ) u_buf (
      .CLK         (CLK),
      .nRST        (nRST),
      .i_push      (w_push[p]),
      .i_push_pr   (wr_req_PR_by_port[p]),
      .i_push_data (wr_req_data_by_port[p]),
      .i_pop       (w_pop[p]),
      .o_head_pr   (w_head_pr[p]),
      .o_head_data (w_head_data[p]),
      .o_count     (w_count[p]),
      .o_ready     (w_ready[p])
    );
  end

  // A head targets exactly one bank, so at most one grant per port can be set.
  always_comb begin
    w_pop = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      w_pop = w_pop | w_grant[b];
    end
  end

  for (genvar b = 0; b < PRF_BANK_COUNT; b++) begin : g_bank
    logic [2:0]              r_rr;
    logic                    r_valid;
    logic [4:0]              r_upper;
    logic [XLEN-1:0]         r_data;
    logic [6:0]              r_pr;
    logic [PRF_WR_COUNT-1:0] w_cand;
    logic [3:0]              w_pick;
    logic                    w_found;
    logic                    w_rr_upd;
    logic [2:0]              w_win;

    always_comb begin
      w_cand = '0;
      for (int p = 0; p < PRF_WR_COUNT; p++) begin
        w_cand[p] = (w_count[p] != '0) && (PR_bank_bits(w_head_pr[p]) == PR_bank_t'(b));
      end
    end

    always_comb begin
      w_pick   = rr_pick(w_cand, r_rr);
      w_found  = w_pick[3];
      w_win    = w_pick[2:0];
      w_rr_upd = w_pick[3];
`ifdef PRF_WR_ARB_WRBUF_PRIO_EN
      // WR_BUF wins outright and leaves the pointer alone; with it absent the
      // round-robin search over the remaining candidates never lands on port 0.
      if (w_cand[0]) begin
        w_found  = 1'b1;
        w_win    = '0;
        w_rr_upd = 1'b0;
      end
`endif
    end

    assign w_grant[b] = w_found ? (PRF_WR_COUNT'(1) << w_win) : '0;

    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        r_rr    <= '0;
        r_valid <= 1'b0;
        r_upper <= '0;
        r_data  <= '0;
        r_pr    <= '0;
      end else begin
        r_valid <= w_found;
        if (w_rr_upd) r_rr <= w_win + 3'd1;
        if (w_found) begin
          r_upper <= upper_PR_bits(w_head_pr[w_win]);
          r_data  <= w_head_data[w_win];
          r_pr    <= w_head_pr[w_win];
        end
      end
    end

    assign prf_wr_valid_by_bank[b]    = r_valid;
    assign prf_wr_upper_PR_by_bank[b] = r_upper;
    assign prf_wr_data_by_bank[b]     = r_data;
    assign wb_bcast_valid_by_bank[b]  = r_valid;
    assign wb_bcast_PR_by_bank[b]     = r_pr;
  end

endmodule

`default_nettype wire

// File: tb/tb_prf_wr_arbiter.sv
// Scoreboard bench for prf_wr_arbiter: queue-based reference model plus directed checks.
`default_nettype none
`timescale 1ns/1ps

module tb_prf_wr_arbiter;
  import corep::*;

  localparam int NP = 8;
  localparam int NB = 4;

  logic                     CLK = 1'b0;
  logic                     nRST = 1'b0;
  logic [NP-1:0]            vld;
  logic [NP-1:0][6:0]       pr;
  logic [NP-1:0][31:0]      dat;
  logic [NP-1:0]            rdy;
  logic [NB-1:0]            wr_v;
  logic [NB-1:0][4:0]       wr_up;
  logic [NB-1:0][31:0]      wr_d;
  logic [NB-1:0]            bc_v;
  logic [NB-1:0][6:0]       bc_pr;

  always #5 CLK = ~CLK;

  prf_wr_arbiter dut (
    .CLK                     (CLK),
    .nRST                    (nRST),
    .wr_req_valid_by_port    (vld),
    .wr_req_PR_by_port       (pr),
    .wr_req_data_by_port     (dat),
    .wr_req_ready_by_port    (rdy),
    .prf_wr_valid_by_bank    (wr_v),
    .prf_wr_upper_PR_by_bank (wr_up),
    .prf_wr_data_by_bank     (wr_d),
    .wb_bcast_valid_by_bank  (bc_v),
    .wb_bcast_PR_by_bank     (bc_pr)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [NB-1:0]       v;
    logic [NB-1:0][6:0]  pr;
    logic [NB-1:0][31:0] d;
  } exp_t;

  exp_t        exp_q[$];
  logic [6:0]  mq_pr[NP][$];
  logic [31:0] mq_d [NP][$];
  int          rr[NB];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      mq_pr[p].delete();
      mq_d[p].delete();
    end
    for (int b = 0; b < NB; b++) rr[b] = 0;
    exp_q.delete();
  endtask

  function automatic bit heads_bank(input int p, input int b);
    logic [6:0] h;
    if (mq_pr[p].size() == 0) return 1'b0;
    h = mq_pr[p][0];
    return (int'(h[1:0]) == b);
  endfunction

  // Reference model: each edge, every bank picks from the queue heads, then pops and pushes.
  always @(posedge CLK) begin
    exp_t e;
    bit   acc[NP];
    bit   taken[NP];
    int   w;
    if (nRST) begin
      e = '0;
      for (int p = 0; p < NP; p++) begin
        acc[p]   = vld[p] && (mq_pr[p].size() < 2);
        taken[p] = 1'b0;
      end
      for (int b = 0; b < NB; b++) begin
        w = -1;
`ifdef PRF_WR_ARB_WRBUF_PRIO_EN
        if (heads_bank(0, b)) w = 0;
        else begin
          for (int i = 0; i < NP; i++)
            if (w < 0 && ((rr[b] + i) % NP) != 0 && heads_bank((rr[b] + i) % NP, b)) w = (rr[b] + i) % NP;
          if (w > 0) rr[b] = (w + 1) % NP;
        end
`else
        for (int i = 0; i < NP; i++)
          if (w < 0 && heads_bank((rr[b] + i) % NP, b)) w = (rr[b] + i) % NP;
        if (w >= 0) rr[b] = (w + 1) % NP;
`endif
        if (w >= 0) begin
          e.v[b]   = 1'b1;
          e.pr[b]  = mq_pr[w][0];
          e.d[b]   = mq_d[w][0];
          taken[w] = 1'b1;
        end
      end
      for (int p = 0; p < NP; p++) begin
        if (taken[p]) begin
          void'(mq_pr[p].pop_front());
          void'(mq_d[p].pop_front());
        end
        if (acc[p]) begin
          mq_pr[p].push_back(pr[p]);
          mq_d[p].push_back(dat[p]);
        end
      end
      exp_q.push_back(e);
    end
  end

  // Monitor: compares every cycle's registered outputs and ready against the model.
  always @(negedge CLK) begin
    exp_t          e;
    logic [NP-1:0] mrdy;
    if (!nRST) begin
      chk("reset_wr_valid", 64'(wr_v), 64'(0));
      chk("reset_bcast_valid", 64'(bc_v), 64'(0));
      chk("reset_ready", 64'(rdy), 64'({NP{1'b1}}));
    end else begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      chk("wr_valid", 64'(wr_v), 64'(e.v));
      chk("bcast_valid", 64'(bc_v), 64'(e.v));
      for (int b = 0; b < NB; b++) begin
        if (e.v[b]) begin
          chk($sformatf("upper_PR[%0d]", b), 64'(wr_up[b]), 64'(e.pr[b][6:2]));
          chk($sformatf("data[%0d]", b), 64'(wr_d[b]), 64'(e.d[b]));
          chk($sformatf("bcast_PR[%0d]", b), 64'(bc_pr[b]), 64'(e.pr[b]));
        end
      end
      for (int p = 0; p < NP; p++) mrdy[p] = (mq_pr[p].size() < 2);
      chk("ready", 64'(rdy), 64'(mrdy));
    end
  end

  task automatic drive_step();
    @(negedge CLK);
    #2;
  endtask

  int pct[3] = '{30, 60, 95};

  initial begin
    vld = '0;
    pr  = '0;
    dat = '0;
    model_reset();
    repeat (3) @(negedge CLK);
    #2 nRST = 1'b1;

    // Single write: port 3, PR 0x15 lands on bank 1 row 5.
    drive_step();
    vld[3] = 1'b1; pr[3] = 7'h15; dat[3] = 32'hDEAD;
    drive_step();
    vld = '0;
    @(negedge CLK);
    chk("single_valid", 64'(wr_v), 64'(4'b0010));
    chk("single_upper", 64'(wr_up[1]), 64'(5));
    chk("single_data", 64'(wr_d[1]), 64'(32'hDEAD));
    chk("single_bcast", 64'(bc_pr[1]), 64'(7'h15));

    // Contention on bank 0 from ports 1, 2, 5 with rr[0]=0.
    drive_step();
    vld[1] = 1'b1; pr[1] = 7'h04; dat[1] = 32'h1111;
    vld[2] = 1'b1; pr[2] = 7'h08; dat[2] = 32'h2222;
    vld[5] = 1'b1; pr[5] = 7'h0C; dat[5] = 32'h5555;
    drive_step();
    vld = '0;
    @(negedge CLK);
    chk("rr_first", 64'(bc_pr[0]), 64'(7'h04));
    @(negedge CLK);
    chk("rr_second", 64'(bc_pr[0]), 64'(7'h08));
    @(negedge CLK);
    chk("rr_third", 64'(bc_pr[0]), 64'(7'h0C));

    // Wrap-around: ports 7 and 0 on bank 0 with rr[0]=6.
    #2;
    vld[7] = 1'b1; pr[7] = 7'h10; dat[7] = 32'h7777;
    vld[0] = 1'b1; pr[0] = 7'h20; dat[0] = 32'h0000_0C0C;
    drive_step();
    vld = '0;
    @(negedge CLK);
`ifdef PRF_WR_ARB_WRBUF_PRIO_EN
    chk("wrap_first", 64'(bc_pr[0]), 64'(7'h20));
    @(negedge CLK);
    chk("wrap_second", 64'(bc_pr[0]), 64'(7'h10));
`else
    chk("wrap_first", 64'(bc_pr[0]), 64'(7'h10));
    @(negedge CLK);
    chk("wrap_second", 64'(bc_pr[0]), 64'(7'h20));
`endif

    // Parallel banks: ports 0..3 target banks 0..3.
    #2;
    for (int p = 0; p < 4; p++) begin
      vld[p] = 1'b1;
      pr[p]  = {5'(p + 8), 2'(p)};
      dat[p] = 32'hA000 + 32'(p);
    end
    drive_step();
    vld = '0;
    @(negedge CLK);
    chk("parallel_valid", 64'(wr_v), 64'(4'hF));

    // Port 0 against port 6 on bank 2 with rr[2]=3.
    #2;
    vld[0] = 1'b1; pr[0] = 7'h32; dat[0] = 32'hB000;
    vld[6] = 1'b1; pr[6] = 7'h36; dat[6] = 32'hB006;
    drive_step();
    vld = '0;
    @(negedge CLK);
`ifdef PRF_WR_ARB_WRBUF_PRIO_EN
    chk("prio_bank2", 64'(bc_pr[2]), 64'(7'h32));
`else
    chk("prio_bank2", 64'(bc_pr[2]), 64'(7'h36));
`endif

    // Backpressure: four ports flood bank 3.
    for (int c = 0; c < 12; c++) begin
      drive_step();
      for (int p = 4; p < 8; p++) begin
        vld[p] = 1'b1;
        pr[p]  = {5'($urandom_range(31)), 2'd3};
        dat[p] = $urandom;
      end
    end
    drive_step();
    vld = '0;

    // Randomized traffic; phase 2 skews toward bank 0, phase 1 includes a mid-run reset.
    for (int ph = 0; ph < 3; ph++) begin
      for (int c = 0; c < 400; c++) begin
        drive_step();
        if (ph == 1 && c == 200) begin
          nRST = 1'b0;
          model_reset();
        end else if (ph == 1 && c == 203) begin
          nRST = 1'b1;
        end
        for (int p = 0; p < NP; p++) begin
          vld[p] = nRST && ($urandom_range(99) < pct[ph]);
          pr[p]  = 7'($urandom_range(127));
          if (ph == 2 && $urandom_range(3) != 0) pr[p][1:0] = 2'd0;
          dat[p] = $urandom;
        end
      end
    end

    drive_step();
    vld = '0;
    repeat (12) @(negedge CLK);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/prf_wr_arbiter.md
# prf_wr_arbiter

Shares the four physical register file write banks among the eight writeback requesters (WR_BUF, LDU bank 0, LDU bank 1, ALU Reg-Reg, MDU, ALU Reg-Imm, BRU, SYSU). Each requester has a small input buffer. Per cycle, each bank grants at most one buffered write, chosen by round-robin. Granted writes drive the PRF bank write ports and a matching writeback broadcast used for wakeup and ROB completion.

## Interface
Parameters:
- PRF_WR_COUNT, 8, number of write requesters; port index = requester order above
- PRF_BANK_COUNT, 4, number of PRF banks
- PRF_WR_INPUT_BUFFER_SIZE, 2, entries per requester input buffer

Ports (clock is CLK; reset is nRST, asynchronous, active-low):
- CLK  input  1  clock
- nRST  input  1  asynchronous active-low reset
- wr_req_valid_by_port  input  [PRF_WR_COUNT]  write request valid
- wr_req_PR_by_port  input  [PRF_WR_COUNT] x PR_t (7b)  destination PR
- wr_req_data_by_port  input  [PRF_WR_COUNT] x XLEN  write data
- wr_req_ready_by_port  output  [PRF_WR_COUNT]  buffer can accept
- prf_wr_valid_by_bank  output  [PRF_BANK_COUNT]  bank write enable
- prf_wr_upper_PR_by_bank  output  [PRF_BANK_COUNT] x upper_PR_t (5b)  bank row
- prf_wr_data_by_bank  output  [PRF_BANK_COUNT] x XLEN  bank write data
- wb_bcast_valid_by_bank  output  [PRF_BANK_COUNT]  writeback broadcast valid
- wb_bcast_PR_by_bank  output  [PRF_BANK_COUNT] x PR_t  full PR broadcast

## Operation
- Enqueue: when valid && ready on port p, the request is pushed into buffer p at the clock edge.
- Ready: ready[p] = (count[p] < PRF_WR_INPUT_BUFFER_SIZE). It is computed from the registered count only. A same-cycle dequeue does not raise ready.
- Per bank b, the candidate set is the ports whose buffer is non-empty and whose head PR_bank_bits(PR) == b.
- Each bank keeps a 3-bit round-robin pointer rr[b], which names the highest-priority port.
  - The winner is the first candidate at or after rr[b], searching modulo PRF_WR_COUNT.
  - After a grant to port p, rr[b] becomes (p+1) mod 8. For example, p=7 wraps to 0.
  - With no grant, rr[b] is held.
- The winner's head is popped at the same edge.
- A port has only one head, so at most one bank can grant it per cycle. Banks are independent.
- Output registers load the winner: valid=1, upper_PR_bits(PR), data, full PR. With no winner, valid=0 and the other fields are don't-care (hold the previous value).
- Simultaneous push and pop on the same port in the same cycle: count is unchanged, and FIFO order is preserved.
- Duplicate PR values are not checked; they are forwarded as received.
- Reset (at any time):
  - All buffers empty; count=0.
  - rr[b]=0.
  - All valid outputs 0.
  - wr_req_ready_by_port all 1 after reset.
  - In-flight buffered writes are discarded.

## Timing
- Request accepted at edge N (end of cycle N).
- Arbitration happens combinationally from the buffer head in cycle N+1.
- prf_wr_* and wb_bcast_* are registered and visible in cycle N+2. Minimum latency is 2 cycles, with no bypass path.
- Sustained throughput is 1 write/cycle/port when that port's bank is uncontended, and 4 writes/cycle total across banks.
- With the buffer full and a pop in cycle N+1, ready rises in cycle N+2.

## Configuration
- PRF_WR_ARB_WRBUF_PRIO_EN:
  - Defined: port 0 (WR_BUF) always wins its bank whenever its head targets that bank. A port-0 grant does not update rr[b]. Ports 1..7 round-robin among themselves via rr[b], which skips port 0.
  - Undefined: port 0 takes part in round-robin like every other port.

## Structure
- Package corep supplies:
  - the parameters PRF_WR_COUNT, PRF_BANK_COUNT, PRF_WR_INPUT_BUFFER_SIZE
  - the types PR_t, upper_PR_t, PR_bank_t
  - the functions upper_PR_bits and PR_bank_bits
  - XLEN_t
- Sub-module prf_wr_port_buffer: a parameterised-depth FIFO holding {PR_t, XLEN_t}, with push, pop, head, count and ready. It is instantiated PRF_WR_COUNT times.
- The round-robin selection is a per-bank generate loop in the top module.

## Test plan
- Single write: port 3 sends PR=0x15 (bank 1), data=0xDEAD at edge 0 → cycle 2 shows prf_wr_valid_by_bank=4'b0010, upper_PR=5, data=0xDEAD, wb_bcast_PR=0x15.
- Contention round-robin: ports 1, 2, 5 hold heads all targeting bank 0, with rr[0]=0 → grants on consecutive cycles go to 1, 2, 5, then rr[0]=6.
- Wrap-around: rr[0]=6, with ports 7 and 0 contending on bank 0 → 7 is granted, then 0; rr[0] goes 0, then 1.
- Full/backpressure: port 4 has 2 entries queued to a bank blocked by higher-priority traffic → ready[4]=0. After one pop, ready[4]=1 the following cycle, and there is no overflow or loss.
- Parallel banks: ports 0–3 target banks 0–3 in the same cycle → all four valids are set in one cycle. With PRF_WR_ARB_WRBUF_PRIO_EN defined, port 0 beats port 6 on bank 2 regardless of rr[2].
- Reset mid-operation: assert nRST low with 5 buffered entries → outputs invalid immediately, ready all 1 after release, and no stale write appears.
